// File: rtl/password_programmer.sv
// Password programming controller: enter a code, confirm it, then commit it
// to the password memory one digit per cycle. All outputs are registered.
module password_programmer #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4,
    localparam int ADDR_W = (DIGITS > 2) ? $clog2(DIGITS) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               cancel,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] mem_data,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic               busy,
    output logic               done,
    output logic               mismatch,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER   = 3'd1,
        CONFIRM = 3'd2,
        COMMIT  = 3'd3
    } state_t;

    localparam logic [ADDR_W-1:0]  ZERO_IDX  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0]  ONE_IDX   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(DIGITS - 1);
    localparam logic [DIGIT_W-1:0] ZERO_DATA = DIGIT_W'(0);

    state_t              state_r, state_next_s;
    logic [ADDR_W-1:0]   idx_r, idx_next_s;
    logic                match_r, match_next_s;
    logic [DIGIT_W-1:0]  buf_r [DIGITS];
    logic                buf_we_s;
    logic                digit_eq_s;
    logic                done_next_s, mismatch_next_s;
    logic                mem_we_next_s;
    logic [ADDR_W-1:0]   mem_addr_next_s;
    logic [DIGIT_W-1:0]  mem_data_next_s;

    // Next-state, index/match update and next-cycle output decode
    always_comb begin
        state_next_s    = state_r;
        idx_next_s      = idx_r;
        match_next_s    = match_r;
        buf_we_s        = 1'b0;
        done_next_s     = 1'b0;
        mismatch_next_s = 1'b0;
        digit_eq_s      = (digit == buf_r[idx_r]);
        case (state_r)
            IDLE: begin
                match_next_s = 1'b0;
                // start together with cancel is treated as no request
                if (start && !cancel) begin
                    state_next_s = ENTER;
                    idx_next_s   = ZERO_IDX;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ENTER: begin
                if (cancel) begin
                    state_next_s = IDLE;
                    idx_next_s   = ZERO_IDX;
                end else if (digit_valid) begin
                    buf_we_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_next_s = CONFIRM;
                        idx_next_s   = ZERO_IDX;
                        match_next_s = 1'b1;
                    end else begin
                        idx_next_s = idx_r + ONE_IDX;
                    end
                end else begin
                    state_next_s = ENTER;
                end
            end
            CONFIRM: begin
                if (cancel) begin
                    state_next_s = IDLE;
                    idx_next_s   = ZERO_IDX;
                    match_next_s = 1'b0;
                end else if (digit_valid) begin
                    if (idx_r == LAST_IDX) begin
                        idx_next_s   = ZERO_IDX;
                        match_next_s = 1'b0;
                        if (match_r && digit_eq_s) begin
                            state_next_s = COMMIT;
                        end else begin
                            state_next_s    = IDLE;
                            mismatch_next_s = 1'b1;
                        end
                    end else begin
                        match_next_s = match_r & digit_eq_s;
                        idx_next_s   = idx_r + ONE_IDX;
                    end
                end else begin
                    state_next_s = CONFIRM;
                end
            end
            COMMIT: begin
                // cancel, start and digit_valid are deliberately not looked at here
                if (idx_r == LAST_IDX) begin
                    state_next_s = IDLE;
                    idx_next_s   = ZERO_IDX;
                    done_next_s  = 1'b1;
                end else begin
                    idx_next_s = idx_r + ONE_IDX;
                end
            end
            default: begin
                state_next_s = IDLE;
                idx_next_s   = ZERO_IDX;
                match_next_s = 1'b0;
            end
        endcase
        mem_we_next_s   = (state_next_s == COMMIT);
        mem_addr_next_s = mem_we_next_s ? idx_next_s : ZERO_IDX;
        mem_data_next_s = mem_we_next_s ? buf_r[idx_next_s] : ZERO_DATA;
    end

    // FSM state, index, match flag and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= IDLE;
            idx_r     <= ZERO_IDX;
            match_r   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= ZERO_IDX;
            mem_data  <= ZERO_DATA;
            busy      <= 1'b0;
            done      <= 1'b0;
            mismatch  <= 1'b0;
            dbg_state <= 3'd0;
        end else begin
            state_r   <= state_next_s;
            idx_r     <= idx_next_s;
            match_r   <= match_next_s;
            mem_we    <= mem_we_next_s;
            mem_addr  <= mem_addr_next_s;
            mem_data  <= mem_data_next_s;
            busy      <= (state_next_s != IDLE);
            done      <= done_next_s;
            mismatch  <= mismatch_next_s;
            dbg_state <= state_next_s;
        end
    end

    // Entered-digit buffer
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DIGITS; i++) begin
                buf_r[i] <= ZERO_DATA;
            end
        end else if (buf_we_s) begin
            buf_r[idx_r] <= digit;
        end else begin
            buf_r[idx_r] <= buf_r[idx_r];
        end
    end

endmodule

// File: doc/password_programmer.md
PASSWORD_PROGRAMMER -- requirements
Module: password_programmer

Interface
REQ-001 Parameter DIGITS, default 4: number of password digits; legal range 2..16.
REQ-002 Parameter DIGIT_W, default 4: width of one digit in bits.
REQ-003 Derived ADDR_W = max(1, clog2(DIGITS)); not overridable.
REQ-004 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  request a new programming session; level-sampled each cycle.
REQ-007 cancel  in  1  abort the current session.
REQ-008 digit_valid  in  1  one-cycle strobe; digit is accepted on every rising edge where it is high.
REQ-009 digit  in  DIGIT_W  digit value qualified by digit_valid.
REQ-010 mem_data  out  DIGIT_W  write data to the password memory.
REQ-011 mem_addr  out  ADDR_W  write address to the password memory.
REQ-012 mem_we  out  1  write enable to the password memory.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  one-cycle pulse on a successful commit.
REQ-015 mismatch  out  1  one-cycle pulse on a failed confirmation.
REQ-016 dbg_state  out  3  current state encoding, for debug.

Function
REQ-017 The FSM SHALL have the states IDLE=0, ENTER=1, CONFIRM=2, COMMIT=3.
REQ-018 IDLE: start high -> ENTER with idx=0; digit_valid is ignored.
REQ-019 ENTER: each accepted digit -> buf[idx]<=digit and idx++; an accepted digit at idx=DIGITS-1 -> CONFIRM with idx=0 and match=1.
REQ-020 CONFIRM: each accepted digit is compared with buf[idx]; inequality clears match; idx++.
REQ-021 CONFIRM, accepted digit at idx=DIGITS-1: if match and the final compare are both true -> COMMIT with idx=0; otherwise -> IDLE with mismatch high for the next cycle.
REQ-022 COMMIT: each cycle drive mem_we=1, mem_addr=idx, mem_data=buf[idx], then idx++; addresses issue in ascending order 0..DIGITS-1, exactly once each.
REQ-023 After the write at idx=DIGITS-1: go to IDLE, with done high for exactly the next cycle.
REQ-024 Outside COMMIT: mem_we, mem_addr and mem_data SHALL be 0.
REQ-025 Memory is never written during ENTER or CONFIRM, nor in any aborted or mismatched session.
REQ-026 cancel high in ENTER or CONFIRM -> IDLE next edge with no write and no done/mismatch; cancel takes priority over a simultaneous digit_valid.
REQ-027 cancel is ignored in COMMIT: the commit is atomic once started.
REQ-028 start is ignored while busy.
REQ-029 In IDLE, start and cancel high together -> remain IDLE.
REQ-030 digit_valid is ignored in IDLE and COMMIT.
REQ-031 Latency: the first write occurs in the cycle after the last confirm digit is accepted; done follows DIGITS cycles later.
REQ-032 idx SHALL never exceed DIGITS-1 and SHALL reset to 0 on every state change.

Reset
REQ-033 RST low SHALL force, immediately and independent of CLK: state IDLE, idx 0, match 0, buf all zero, and every output 0.
REQ-034 RST asserted mid-session (including mid-COMMIT) SHALL abandon the session; already-issued writes are not undone, and no further writes occur.
REQ-035 After RST deasserts, the block SHALL stay in IDLE until start is sampled high.

Verification (DIGITS=4, DIGIT_W=4)
REQ-036 Scenario: start; enter 3,1,4,1; confirm 3,1,4,1 -> writes (0,3),(1,1),(2,4),(3,1) on 4 consecutive cycles, then one done pulse, busy low.
REQ-037 Scenario: enter 3,1,4,1; confirm 3,1,5,1 -> mismatch pulse, no mem_we at any cycle, return to IDLE.
REQ-038 Scenario: cancel asserted with the 2nd confirm digit -> IDLE, no writes, no done or mismatch; a new session afterwards programs correctly.
REQ-039 Scenario: start and cancel pulsed during COMMIT -> all 4 writes complete and done pulses once.
REQ-040 Scenario: RST low after 2 writes of a commit -> outputs 0 immediately, no further writes, dbg_state=0.
REQ-041 Scenario: DIGITS=6 parameter run with random digits -> 6 ordered writes matching the entry.
